// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: drives a byte-level SPI engine to issue one SD SPI-mode
// command frame, poll for R1 and optionally collect 4 trailing bytes.
// Ports: clk, rst_n (sync, active low); start/cmd_index/cmd_arg/long_resp/
// keep_cs request; cs, spi_execute/spi_tx_byte/spi_rx_byte/spi_finished
// engine handshake; busy/done/timeout/r1/resp_data results to the caller.
module sd_cmd_sequencer #(
    parameter int NCR_MAX   = 8,
    parameter int PRE_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        long_resp,
    input  logic        keep_cs,
    output logic        cs,
    output logic        spi_execute,
    output logic [7:0]  spi_tx_byte,
    input  logic [7:0]  spi_rx_byte,
    input  logic        spi_finished,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  r1,
    output logic [31:0] resp_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_CMD,
        S_POLL,
        S_DATA,
        S_POST,
        S_DONE
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(PRE_BYTES - 1);
    localparam logic [7:0] NCR_LAST = 8'(NCR_MAX - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        pending;
    logic [5:0]  idx_q;
    logic [31:0] arg_q;
    logic        long_q;
    logic        keep_q;
    logic [6:0]  crc_q;

    logic [7:0]  frame_byte;
    logic [7:0]  tx_next;
    logic        byte_state;
    logic        fin;

    // CRC7 (x^7 + x^3 + 1), MSB first over the 40 header/argument bits.
    function automatic logic [6:0] crc7(input logic [39:0] bits);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = bits[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    always_comb begin
        frame_byte = 8'hFF;
        case (cnt[2:0])
            3'd0:    frame_byte = {2'b01, idx_q};
            3'd1:    frame_byte = arg_q[31:24];
            3'd2:    frame_byte = arg_q[23:16];
            3'd3:    frame_byte = arg_q[15:8];
            3'd4:    frame_byte = arg_q[7:0];
            3'd5:    frame_byte = {crc_q, 1'b1};
            default: frame_byte = 8'hFF;
        endcase
    end

    assign tx_next = (state == S_CMD) ? frame_byte : 8'hFF;

    // States that move a byte through the engine; POST only when deselecting.
    assign byte_state = (state == S_PRE) || (state == S_CMD) ||
                        (state == S_POLL) || (state == S_DATA) ||
                        ((state == S_POST) && !keep_q);

    // Only a finish for a byte we actually launched counts.
    assign fin = pending && spi_finished;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            pending     <= 1'b0;
            idx_q       <= '0;
            arg_q       <= '0;
            long_q      <= 1'b0;
            keep_q      <= 1'b0;
            crc_q       <= '0;
            cs          <= 1'b1;
            spi_execute <= 1'b0;
            spi_tx_byte <= 8'hFF;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            r1          <= 8'hFF;
            resp_data   <= '0;
        end else begin
            spi_execute <= 1'b0;
            done        <= 1'b0;

            if (byte_state && !pending) begin
                spi_execute <= 1'b1;
                spi_tx_byte <= tx_next;
                pending     <= 1'b1;
            end
            if (fin) begin
                pending <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx_q     <= cmd_index;
                        arg_q     <= cmd_arg;
                        long_q    <= long_resp;
                        keep_q    <= keep_cs;
                        crc_q     <= crc7({2'b01, cmd_index, cmd_arg});
                        cs        <= 1'b0;
                        busy      <= 1'b1;
                        timeout   <= 1'b0;
                        r1        <= 8'hFF;
                        resp_data <= '0;
                        cnt       <= '0;
                        state     <= (PRE_BYTES == 0) ? S_CMD : S_PRE;
                    end
                end
                S_PRE: begin
                    if (fin) begin
                        if (cnt == PRE_LAST) begin
                            cnt   <= '0;
                            state <= S_CMD;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_CMD: begin
                    if (fin) begin
                        if (cnt == 8'd5) begin
                            cnt   <= '0;
                            state <= S_POLL;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_POLL: begin
                    if (fin) begin
                        if (!spi_rx_byte[7]) begin
                            r1    <= spi_rx_byte;
                            cnt   <= '0;
                            state <= long_q ? S_DATA : S_POST;
                        end else if (cnt == NCR_LAST) begin
                            timeout <= 1'b1;
                            r1      <= 8'hFF;
                            cnt     <= '0;
                            state   <= S_POST;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (fin) begin
                        resp_data <= {resp_data[23:0], spi_rx_byte};
                        if (cnt == 8'd3) begin
                            cnt   <= '0;
                            state <= S_POST;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_POST: begin
                    if (keep_q) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        // Deselect together with launching the trailing byte.
                        if (!pending) begin
                            cs <= 1'b1;
                        end
                        if (fin) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
- Sequences the byte-level SPI engine (execute/finished handshake) to issue one SD-card SPI-mode command frame.
- Frame is 6 bytes: start bits + index, 32-bit argument, CRC7 + end bit. The block then polls for the R1 response and optionally collects 4 trailing response bytes (R3/R7).
- Sits between the card-init/read/write state machine and the SPI engine. The upper FSM supplies index/argument and waits for done; it no longer builds frames byte by byte.

Parameters:
- NCR_MAX, 8, maximum number of 0xFF poll bytes sent while waiting for R1 before declaring timeout (1..255).
- PRE_BYTES, 1, number of 0xFF filler bytes sent with cs low before the command frame (0..15).

Ports:
- clk  input  1  master clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  single-cycle request; accepted only in IDLE.
- cmd_index  input  6  command number (e.g. 0, 8, 55, 41).
- cmd_arg  input  32  command argument.
- long_resp  input  1  0 = R1 only; 1 = R1 followed by 4 bytes (R3/R7).
- keep_cs  input  1  1 = leave cs low after completion (e.g. CMD55 followed by ACMDn).
- cs  output  1  card chip select, active low.
- spi_execute  output  1  one-cycle pulse to start one engine byte transfer.
- spi_tx_byte  output  8  byte to transmit; held stable from the spi_execute pulse until spi_finished.
- spi_rx_byte  input  8  received byte; valid in the cycle spi_finished=1.
- spi_finished  input  1  one-cycle pulse from the engine at end of a byte.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.
- timeout  output  1  valid with done; 1 = no R1 within NCR_MAX polls.
- r1  output  8  captured R1; 8'hFF on timeout.
- resp_data  output  32  trailing bytes, first received byte in [31:24].

Behaviour:
- Reset values: cs=1, spi_execute=0, spi_tx_byte=8'hFF, busy=0, done=0, timeout=0, r1=8'hFF, resp_data=0, state=IDLE.
- Reset mid-operation: next edge returns to IDLE with all outputs at reset values. A later spi_finished from the aborted byte is ignored.
- IDLE:
  - On start=1, latch cmd_index, cmd_arg, long_resp and keep_cs.
  - Next cycle: cs=0, busy=1, timeout=0.
  - Go to PRE, or to CMD if PRE_BYTES=0.
  - start while busy is ignored.
- Byte issue rule (every state below): assert spi_execute for exactly 1 cycle with spi_tx_byte set in that same cycle. Wait for spi_finished. The next spi_execute is no earlier than the cycle after spi_finished. spi_finished arriving while no byte is outstanding is ignored.
- PRE: send PRE_BYTES bytes of 0xFF, then go to CMD.
- CMD: send 6 bytes in order:
  - {2'b01, cmd_index}
  - cmd_arg[31:24], [23:16], [15:8], [7:0]
  - {crc7, 1'b1}
  - crc7 uses polynomial x^7+x^3+1, initial value 0, computed MSB-first over the first 40 frame bits. It is precomputed before byte 6 is issued.
- POLL:
  - Send 0xFF; count polls.
  - On spi_finished with spi_rx_byte[7]=0: r1 <= spi_rx_byte; go to DATA if long_resp, else POST.
  - If poll number NCR_MAX completes with bit7=1: timeout <= 1, r1 <= 8'hFF, go to POST (DATA is skipped).
- DATA: send 4 bytes of 0xFF; shift each received byte into resp_data from the MSB end. Then go to POST.
- POST:
  - If keep_cs=0: cs <= 1 and send one 0xFF byte (8 clocks with the card deselected).
  - If keep_cs=1: cs stays 0 and no byte is sent.
  - Then DONE.
- DONE: done=1 for one cycle, busy <= 0, back to IDLE. r1, resp_data and timeout hold until the next accepted start.
- start in the same cycle as done is ignored. The first acceptable start is in the cycle after done.
- An R1 with error bits set (bit7=0) is not a timeout; interpretation is the caller's job.

Test Plan:
- CMD0, arg 0, long_resp=0, PRE_BYTES=1; engine returns FF,FF,01 in POLL -> tx bytes FF,40,00,00,00,00,95,FF,FF,FF,FF; cs low from PRE until POST; r1=01, timeout=0, single done pulse.
- CMD8, arg 0x000001AA, long_resp=1; R1=01 then 00,00,01,AA -> CRC byte 87, r1=01, resp_data=0x000001AA.
- CMD55 keep_cs=1 then CMD41 arg 0x40000000 -> CRC bytes 65 and 77; cs stays 0 between the two commands; after the second command cs=1 after POST.
- No response (rx always FF), NCR_MAX=8 -> exactly 8 poll bytes, timeout=1, r1=FF, DATA skipped even with long_resp=1, cs returns to 1.
- start held high during an operation, plus a stray spi_finished in IDLE -> no second command, no extra spi_execute; busy/done timing unchanged.
- rst_n low during CMD byte 3 -> next edge cs=1, busy=0, spi_execute=0; late spi_finished ignored; a new start runs a clean full frame.
